comp_stream_minmax: RTL and testbench

Streaming min/max tracker, the sequential successor to the 16-bit combinational comparator. It accepts a frame of WIDTH-bit samples over a valid/ready handshake and compares each sample against running minimum and maximum registers. At frame end it presents min, max, their first-occurrence indices, the sample count and an overflow flag on a held result interface. It sits between the ALU datapath and the MCU result bus for peak/valley detection.

---
 rtl/comp_stream_minmax_pkg.sv | 35 +++
 rtl/comp_stream_minmax_if.sv | 47 ++++
 rtl/comp_stream_minmax_cell.sv | 30 +++
 rtl/comp_stream_minmax.sv | 191 +++++++++++++++++++
 tb/tb_comp_stream_minmax.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/comp_stream_minmax_pkg.sv
// ----------------------------------------------------------------------------
// comp_pkg
// Shared definitions for the streaming min/max tracker:
//   - state_e       : frame tracker states (IDLE / ACC / HOLD)
//   - MODE_*        : compare-mode encodings used by the mode register
//   - clog2()       : index-width helper, never returns less than 1
// ----------------------------------------------------------------------------
package comp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

    // Floor of 1 keeps index buses at least one bit wide for tiny frames.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/comp_stream_minmax_if.sv
// ----------------------------------------------------------------------------
// comp_stream_minmax_if
// Sample stream (valid/ready) plus held result bus of the min/max tracker.
//   slave  : the tracker (accepts samples, produces results)
//   master : the producer/consumer connected to the tracker
// Signals:
//   in_valid/in_ready/in_data/in_last : sample handshake
//   res_valid/res_ready               : result handshake
//   res_min/res_max                   : frame extremes
//   res_min_idx/res_max_idx           : first-occurrence indices
//   res_count/res_ovf                 : sample count and length overflow
// ----------------------------------------------------------------------------
interface comp_stream_minmax_if
    import comp_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int MAX_LEN = 256
);
    localparam int IDXW = clog2(MAX_LEN);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_min;
    logic [WIDTH-1:0] res_max;
    logic [IDXW-1:0]  res_min_idx;
    logic [IDXW-1:0]  res_max_idx;
    logic [IDXW:0]    res_count;
    logic             res_ovf;

    modport slave (
        input  in_valid, in_data, in_last, res_ready,
        output in_ready, res_valid, res_min, res_max,
               res_min_idx, res_max_idx, res_count, res_ovf
    );

    modport master (
        output in_valid, in_data, in_last, res_ready,
        input  in_ready, res_valid, res_min, res_max,
               res_min_idx, res_max_idx, res_count, res_ovf
    );

endinterface

// File: rtl/comp_stream_minmax_cell.sv
// ----------------------------------------------------------------------------
// comp_cell
// Combinational magnitude compare of two WIDTH-bit values.
// Ports:
//   a, b       : operands
//   is_signed  : 1 = two's complement, 0 = unsigned
//   lt, gt     : a < b, a > b
// ----------------------------------------------------------------------------
module comp_cell #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             lt,
    output logic             gt
);

    logic [WIDTH-1:0] aAdj;
    logic [WIDTH-1:0] bAdj;

    // Flipping the sign bit maps two's complement order onto unsigned order,
    // so one full-range unsigned compare serves both modes.
    assign aAdj = {a[WIDTH-1] ^ is_signed, a[WIDTH-2:0]};
    assign bAdj = {b[WIDTH-1] ^ is_signed, b[WIDTH-2:0]};

    assign lt = (aAdj < bAdj);
    assign gt = (aAdj > bAdj);

endmodule

// File: rtl/comp_stream_minmax.sv
// ----------------------------------------------------------------------------
// comp_stream_minmax
// Streaming min/max tracker. Accepts a frame of samples, tracks the running
// minimum/maximum with first-occurrence indices, and presents the frame
// result on a held result bus until it is consumed.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   clear        : synchronous abort of partial frame and pending result
//   mode_sel     : 0 = SIGNED_DEF mode, 1 = mode_signed
//   mode_signed  : per-frame compare mode, latched with the first sample
//   bus          : sample stream and result bus (slave side)
// ----------------------------------------------------------------------------
module comp_stream_minmax
    import comp_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int MAX_LEN    = 256,
    parameter bit SIGNED_DEF = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 mode_sel,
    input  logic                 mode_signed,
    comp_stream_minmax_if.slave  bus
);

    localparam int IDXW = clog2(MAX_LEN);
    localparam int CNTW = IDXW + 1;
    localparam logic [CNTW-1:0] COUNT_MAX = CNTW'(MAX_LEN);
    localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(MAX_LEN - 1);

    state_e           state_q;
    logic             mode_q;
    logic [WIDTH-1:0] min_q, max_q;
    logic [IDXW-1:0]  minIdx_q, maxIdx_q;
    logic [CNTW-1:0]  count_q;
    logic             ovf_q;

    logic             resValid_q;
    logic [WIDTH-1:0] resMin_q, resMax_q;
    logic [IDXW-1:0]  resMinIdx_q, resMaxIdx_q;
    logic [CNTW-1:0]  resCount_q;
    logic             resOvf_q;

    logic [WIDTH-1:0] min_d, max_d;
    logic [IDXW-1:0]  minIdx_d, maxIdx_d;
    logic [CNTW-1:0]  count_d;
    logic             ovf_d;

    logic             inReady;
    logic             accept;
    logic             effMode;
    logic             cmpSigned;
    logic             atLimit;
    logic [IDXW-1:0]  position;
    logic             newMin, newMax;
    logic             unusedMinGt, unusedMaxLt;

    assign inReady   = ~rst & (state_q != HOLD) & ~clear;
    assign accept    = bus.in_valid & inReady;
    assign effMode   = mode_sel ? mode_signed : SIGNED_DEF;
    // The first sample of a frame compares under the mode it is latching.
    assign cmpSigned = (state_q == IDLE) ? effMode : mode_q;

    // Once the frame is full, later extremes are pinned to the last index.
    assign atLimit  = (count_q == COUNT_MAX);
    assign position = atLimit ? IDX_LAST : count_q[IDXW-1:0];

    comp_cell #(.WIDTH(WIDTH)) minCell (
        .a         (bus.in_data),
        .b         (min_q),
        .is_signed (cmpSigned),
        .lt        (newMin),
        .gt        (unusedMinGt)
    );

    comp_cell #(.WIDTH(WIDTH)) maxCell (
        .a         (bus.in_data),
        .b         (max_q),
        .is_signed (cmpSigned),
        .lt        (unusedMaxLt),
        .gt        (newMax)
    );

    // Accumulator values including the sample currently on the bus.
    always_comb begin
        min_d    = min_q;
        max_d    = max_q;
        minIdx_d = minIdx_q;
        maxIdx_d = maxIdx_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (state_q == IDLE) begin
            min_d    = bus.in_data;
            max_d    = bus.in_data;
            minIdx_d = '0;
            maxIdx_d = '0;
            count_d  = CNTW'(1);
            ovf_d    = 1'b0;
        end else begin
            if (newMin) begin
                min_d    = bus.in_data;
                minIdx_d = position;
            end
            if (newMax) begin
                max_d    = bus.in_data;
                maxIdx_d = position;
            end
            count_d = atLimit ? count_q : count_q + CNTW'(1);
            ovf_d   = ovf_q | atLimit;
        end
    end

    // Frame FSM; result registers load in the same edge as the last sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= SIGNED_DEF;
            min_q       <= '0;
            max_q       <= '0;
            minIdx_q    <= '0;
            maxIdx_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            resValid_q  <= 1'b0;
            resMin_q    <= '0;
            resMax_q    <= '0;
            resMinIdx_q <= '0;
            resMaxIdx_q <= '0;
            resCount_q  <= '0;
            resOvf_q    <= 1'b0;
        end else if (clear) begin
            state_q    <= IDLE;
            resValid_q <= 1'b0;
            min_q      <= '0;
            max_q      <= '0;
            minIdx_q   <= '0;
            maxIdx_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ACC: begin
                    if (accept) begin
                        min_q    <= min_d;
                        max_q    <= max_d;
                        minIdx_q <= minIdx_d;
                        maxIdx_q <= maxIdx_d;
                        count_q  <= count_d;
                        ovf_q    <= ovf_d;
                        if (state_q == IDLE) begin
                            mode_q <= effMode;
                        end
                        if (bus.in_last) begin
                            state_q     <= HOLD;
                            resValid_q  <= 1'b1;
                            resMin_q    <= min_d;
                            resMax_q    <= max_d;
                            resMinIdx_q <= minIdx_d;
                            resMaxIdx_q <= maxIdx_d;
                            resCount_q  <= count_d;
                            resOvf_q    <= ovf_d;
                        end else begin
                            state_q <= ACC;
                        end
                    end
                end
                HOLD: begin
                    if (bus.res_ready) begin
                        state_q    <= IDLE;
                        resValid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready    = inReady;
    assign bus.res_valid   = resValid_q;
    assign bus.res_min     = resMin_q;
    assign bus.res_max     = resMax_q;
    assign bus.res_min_idx = resMinIdx_q;
    assign bus.res_max_idx = resMaxIdx_q;
    assign bus.res_count   = resCount_q;
    assign bus.res_ovf     = resOvf_q;

endmodule

// File: tb/tb_comp_stream_minmax.sv
// ----------------------------------------------------------------------------
// tb_comp_stream_minmax
// Directed bench for the streaming min/max tracker. dutA uses the default
// frame length of 256, dutB a frame length of 4 to reach the overflow path.
// ----------------------------------------------------------------------------
module tb_comp_stream_minmax;

    logic clk;
    logic rst;
    logic clear;
    logic mode_sel;
    logic mode_signed;

    int checks;
    int errors;

    comp_stream_minmax_if #(.WIDTH(16), .MAX_LEN(256)) ifA ();
    comp_stream_minmax_if #(.WIDTH(16), .MAX_LEN(4))   ifB ();

    comp_stream_minmax #(.WIDTH(16), .MAX_LEN(256), .SIGNED_DEF(1'b1)) dutA (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .mode_sel    (mode_sel),
        .mode_signed (mode_signed),
        .bus         (ifA)
    );

    comp_stream_minmax #(.WIDTH(16), .MAX_LEN(4), .SIGNED_DEF(1'b1)) dutB (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .mode_sel    (mode_sel),
        .mode_signed (mode_signed),
        .bus         (ifB)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global time bound so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge; presents one sample for one full cycle.
    task automatic applyStimulus(input bit selB, input logic [15:0] data, input logic last);
        if (selB) begin
            ifB.in_valid = 1'b1;
            ifB.in_data  = data;
            ifB.in_last  = last;
        end else begin
            ifA.in_valid = 1'b1;
            ifA.in_data  = data;
            ifA.in_last  = last;
        end
        @(negedge clk);
        ifA.in_valid = 1'b0;
        ifA.in_last  = 1'b0;
        ifB.in_valid = 1'b0;
        ifB.in_last  = 1'b0;
    endtask

    task automatic consumeA();
        ifA.res_ready = 1'b1;
        @(negedge clk);
        ifA.res_ready = 1'b0;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        clear        = 1'b0;
        mode_sel     = 1'b0;
        mode_signed  = 1'b0;
        ifA.in_valid = 1'b0;
        ifA.in_data  = '0;
        ifA.in_last  = 1'b0;
        ifA.res_ready = 1'b0;
        ifB.in_valid = 1'b0;
        ifB.in_data  = '0;
        ifB.in_last  = 1'b0;
        ifB.res_ready = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", 32'(ifA.in_ready), 32'd0);
        checkOutput("rst_res_valid", 32'(ifA.res_valid), 32'd0);
        checkOutput("rst_res_min", 32'(ifA.res_min), 32'd0);
        checkOutput("rst_res_count", 32'(ifA.res_count), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", 32'(ifA.in_ready), 32'd1);

        // Reset in the middle of a frame
        @(negedge clk);
        applyStimulus(1'b0, 16'd40, 1'b0);
        applyStimulus(1'b0, 16'd2, 1'b0);
        applyStimulus(1'b0, 16'd90, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("midrst_in_ready", 32'(ifA.in_ready), 32'd0);
        checkOutput("midrst_res_valid", 32'(ifA.res_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midrst_in_ready_after", 32'(ifA.in_ready), 32'd1);
        @(negedge clk);
        applyStimulus(1'b0, 16'd5, 1'b1);
        checkOutput("single_res_valid", 32'(ifA.res_valid), 32'd1);
        checkOutput("single_min", 32'(ifA.res_min), 32'd5);
        checkOutput("single_max", 32'(ifA.res_max), 32'd5);
        checkOutput("single_min_idx", 32'(ifA.res_min_idx), 32'd0);
        checkOutput("single_max_idx", 32'(ifA.res_max_idx), 32'd0);
        checkOutput("single_count", 32'(ifA.res_count), 32'd1);
        consumeA();
        checkOutput("single_consumed", 32'(ifA.res_valid), 32'd0);

        // Signed frame with full-range extremes and a repeated minimum
        applyStimulus(1'b0, 16'd3, 1'b0);
        applyStimulus(1'b0, 16'h8000, 1'b0);
        applyStimulus(1'b0, 16'h7FFF, 1'b0);
        applyStimulus(1'b0, 16'h8000, 1'b0);
        applyStimulus(1'b0, 16'd7, 1'b1);
        checkOutput("signed_res_valid", 32'(ifA.res_valid), 32'd1);
        checkOutput("signed_min", 32'(ifA.res_min), 32'h8000);
        checkOutput("signed_min_idx", 32'(ifA.res_min_idx), 32'd1);
        checkOutput("signed_max", 32'(ifA.res_max), 32'h7FFF);
        checkOutput("signed_max_idx", 32'(ifA.res_max_idx), 32'd2);
        checkOutput("signed_count", 32'(ifA.res_count), 32'd5);
        checkOutput("signed_ovf", 32'(ifA.res_ovf), 32'd0);

        // Backpressure: result held, no samples taken while pending
        ifA.in_valid = 1'b1;
        ifA.in_data  = 16'h1234;
        ifA.in_last  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("hold_in_ready", 32'(ifA.in_ready), 32'd0);
            checkOutput("hold_res_valid", 32'(ifA.res_valid), 32'd1);
            checkOutput("hold_res_min", 32'(ifA.res_min), 32'h8000);
            checkOutput("hold_res_max", 32'(ifA.res_max), 32'h7FFF);
            checkOutput("hold_res_count", 32'(ifA.res_count), 32'd5);
        end
        ifA.in_valid = 1'b0;
        ifA.in_last  = 1'b0;
        consumeA();
        checkOutput("bubble_res_valid", 32'(ifA.res_valid), 32'd0);
        checkOutput("bubble_in_ready", 32'(ifA.in_ready), 32'd1);
        checkOutput("kept_res_min", 32'(ifA.res_min), 32'h8000);

        // Unsigned mode; a mid-frame mode change must not take effect
        mode_sel    = 1'b1;
        mode_signed = 1'b0;
        applyStimulus(1'b0, 16'd3, 1'b0);
        mode_sel = 1'b0;
        applyStimulus(1'b0, 16'h8000, 1'b0);
        applyStimulus(1'b0, 16'h7FFF, 1'b0);
        applyStimulus(1'b0, 16'h8000, 1'b0);
        applyStimulus(1'b0, 16'd7, 1'b1);
        checkOutput("unsigned_min", 32'(ifA.res_min), 32'd3);
        checkOutput("unsigned_min_idx", 32'(ifA.res_min_idx), 32'd0);
        checkOutput("unsigned_max", 32'(ifA.res_max), 32'h8000);
        checkOutput("unsigned_max_idx", 32'(ifA.res_max_idx), 32'd1);
        checkOutput("unsigned_count", 32'(ifA.res_count), 32'd5);
        consumeA();

        // Unsigned top of range
        mode_sel    = 1'b1;
        mode_signed = 1'b0;
        applyStimulus(1'b0, 16'h0001, 1'b0);
        applyStimulus(1'b0, 16'hFFFF, 1'b1);
        checkOutput("utop_max", 32'(ifA.res_max), 32'hFFFF);
        checkOutput("utop_max_idx", 32'(ifA.res_max_idx), 32'd1);
        checkOutput("utop_min", 32'(ifA.res_min), 32'h0001);
        consumeA();
        mode_sel = 1'b0;

        // Clear coinciding with the last sample aborts the frame
        applyStimulus(1'b0, 16'h0100, 1'b0);
        applyStimulus(1'b0, 16'h0050, 1'b0);
        ifA.in_valid = 1'b1;
        ifA.in_data  = 16'h0010;
        ifA.in_last  = 1'b1;
        clear        = 1'b1;
        #1;
        checkOutput("clear_in_ready", 32'(ifA.in_ready), 32'd0);
        @(negedge clk);
        checkOutput("clear_res_valid", 32'(ifA.res_valid), 32'd0);
        clear        = 1'b0;
        ifA.in_valid = 1'b0;
        ifA.in_last  = 1'b0;
        #1;
        checkOutput("clear_in_ready_after", 32'(ifA.in_ready), 32'd1);
        @(negedge clk);
        checkOutput("clear_still_idle", 32'(ifA.res_valid), 32'd0);
        applyStimulus(1'b0, 16'h0020, 1'b0);
        applyStimulus(1'b0, 16'h0030, 1'b1);
        checkOutput("postclr_res_valid", 32'(ifA.res_valid), 32'd1);
        checkOutput("postclr_min", 32'(ifA.res_min), 32'h0020);
        checkOutput("postclr_min_idx", 32'(ifA.res_min_idx), 32'd0);
        checkOutput("postclr_max", 32'(ifA.res_max), 32'h0030);
        checkOutput("postclr_max_idx", 32'(ifA.res_max_idx), 32'd1);
        checkOutput("postclr_count", 32'(ifA.res_count), 32'd2);
        consumeA();

        // Length overflow on the short-frame instance
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1'b1, 16'(i), (i == 6));
        end
        checkOutput("ovf_res_valid", 32'(ifB.res_valid), 32'd1);
        checkOutput("ovf_flag", 32'(ifB.res_ovf), 32'd1);
        checkOutput("ovf_count", 32'(ifB.res_count), 32'd4);
        checkOutput("ovf_max", 32'(ifB.res_max), 32'd6);
        checkOutput("ovf_max_idx", 32'(ifB.res_max_idx), 32'd3);
        checkOutput("ovf_min", 32'(ifB.res_min), 32'd1);
        checkOutput("ovf_min_idx", 32'(ifB.res_min_idx), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
